// File: rtl/deem_filter.sv
// ============================================================================
//  Module      : deem_filter
//  Description : Receive-side de-emphasis filter, y[n] = x[n] + alpha*y[n-1].
//                Signed DW-bit samples, unsigned Q1.15 coefficient with a
//                shadow register, round-half-up scaling, output saturation
//                and a sticky saturation flag. Valid/ready on both sides.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                enable          - gates acceptance of new samples
//                clear           - synchronous flush of filter state
//                coef_load/in    - coefficient shadow write
//                in_valid/ready/data   - sample input handshake
//                out_valid/ready/data  - sample output handshake
//                sat_flag        - sticky clip indicator
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deem_filter #(
    parameter int DW       = 17,
    parameter int CW       = 16,
    parameter int COEF_RST = 30802
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 coef_load,
    input  logic [CW-1:0]        coef_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 sat_flag
);

    localparam int PW = DW + CW;   // product width: signed sample x unsigned coef
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (CW - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [DW-1:0] y_prev;
    logic signed [DW-1:0] x_reg;
    logic [CW-1:0]        coef_shadow;
    logic [CW-1:0]        coef_active;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_rnd;
    logic signed [DW:0]   scaled;
    logic signed [DW:0]   sum;
    logic signed [DW-1:0] sat_val;
    logic                 clipped;
    logic                 accept;

    // rst is included so in_ready reads 0 the moment reset is asserted.
    assign in_ready = (state == IDLE) && enable && !rst;
    assign accept   = in_valid && in_ready;

    // Coefficient is zero-extended so the multiply is signed x unsigned.
    assign prod     = y_prev * $signed({1'b0, coef_active});
    assign prod_rnd = prod + RND;
    // Arithmetic shift of the rounded product: rounds half toward +inf.
    assign scaled   = (DW + 1)'(prod_rnd >>> (CW - 1));
    assign sum      = {x_reg[DW-1], x_reg} + scaled;

    // The two top bits of the DW+1 bit sum disagree exactly on overflow.
    always_comb begin
        sat_val = sum[DW-1:0];
        clipped = 1'b0;
        if (sum[DW] != sum[DW-1]) begin
            clipped = 1'b1;
            sat_val = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = CALC;
                CALC:    state_nxt = HOLD;
                HOLD:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and coefficient registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            sat_flag    <= 1'b0;
            y_prev      <= '0;
            x_reg       <= '0;
            coef_shadow <= CW'(COEF_RST);
            coef_active <= CW'(COEF_RST);
        end else begin
            // The coefficient path is untouched by clear.
            if (coef_load) begin
                coef_shadow <= coef_in;
            end
            // Copy only while idle so a sample in flight sees a fixed alpha;
            // on an accept edge this picks up the shadow before any new load.
            if (state == IDLE) begin
                coef_active <= coef_shadow;
            end

            if (clear) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                y_prev    <= '0;
                sat_flag  <= 1'b0;
            end else begin
                if (accept) begin
                    x_reg <= in_data;
                end
                if (state == CALC) begin
                    out_data  <= sat_val;
                    y_prev    <= sat_val;
                    out_valid <= 1'b1;
                    if (clipped) begin
                        sat_flag <= 1'b1;
                    end
                end
                if ((state == HOLD) && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_deem_filter.sv
// ============================================================================
//  Module      : tb_deem_filter
//  Description : Self-checking bench for deem_filter. A driver issues samples
//                and pushes reference results into a queue; a monitor pops and
//                compares on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deem_filter;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               clear;
    logic               coef_load;
    logic [15:0]        coef_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [16:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [16:0] out_data;
    logic               sat_flag;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    longint      m_y      = 0;
    int unsigned m_shadow = 30802;
    bit          m_sat    = 1'b0;
    longint      exp_q[$];

    deem_filter #(.DW(17), .CW(16), .COEF_RST(30802)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clear     (clear),
        .coef_load (coef_load),
        .coef_in   (coef_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, longint act, longint req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    // y = x + round(alpha*y_prev), alpha = c/32768, sum wraps at 18 bits, then clamp.
    function automatic longint model_step(longint x, int unsigned c);
        longint s;
        s = x + ((m_y * longint'(c) + 16384) >>> 15);
        s = s & 64'h3FFFF;
        if (s >= 131072) s = s - 262144;
        if (s > 65535) begin
            s = 65535;
            m_sat = 1'b1;
        end else if (s < -65536) begin
            s = -65536;
            m_sat = 1'b1;
        end
        m_y = s;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_coef(input int unsigned c);
        coef_load = 1'b1;
        coef_in   = 16'(c);
        tick();
        coef_load = 1'b0;
        m_shadow  = c;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        m_y   = 0;
        m_sat = 1'b0;
        check("clear_out_valid", out_valid, 0);
        check("clear_sat_flag", sat_flag, 0);
    endtask

    task automatic drain();
        int budget = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 50) begin
            tick();
            budget++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    // Called and returns at posedge+1. Waits for in_ready, then accepts.
    task automatic send(input longint x, input bit load = 1'b0,
                        input int unsigned newc = 0, input bit clr_calc = 1'b0);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = 17'(x);
        while (!in_ready && waited <= 40) begin
            waited++;
            if (waited >= 3) out_ready = 1'b1;
            tick();
        end
        if (!in_ready) begin
            vectors++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0d, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        coef_load = load;
        coef_in   = 16'(newc);
        exp_q.push_back(model_step(x, m_shadow));
        if (load) m_shadow = newc;
        tick();
        in_valid  = 1'b0;
        coef_load = 1'b0;
        check("calc_in_ready", in_ready, 0);
        check("calc_out_valid", out_valid, 0);
        if (clr_calc) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
            void'(exp_q.pop_back());
            m_y   = 0;
            m_sat = 1'b0;
            check("clear_calc_no_valid", out_valid, 0);
            tick();
            check("clear_calc_still_idle", out_valid, 0);
        end else begin
            tick();
            check("latency_out_valid", out_valid, 1);
        end
    endtask

    // Monitor: compares on each output handshake and checks hold stability.
    initial begin
        bit                 held = 1'b0;
        logic signed [16:0] held_val = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held && out_valid) check("hold_stable", out_data, held_val);
                if (out_valid && out_ready && !clear) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_output: got %0d, required none", out_data);
                    end else begin
                        check("out_data", out_data, exp_q.pop_front());
                    end
                end
                held     = out_valid && !out_ready && !clear;
                held_val = out_data;
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b1; clear = 1'b0; coef_load = 1'b0; coef_in = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat_flag", sat_flag, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // Reset coefficient: 1000 then 0 gives round(1000*30802/32768) = 940
        send(1000);
        send(0);
        drain();
        check("coef_rst_result", out_data, 940);

        // Impulse with alpha = 0.5
        do_clear();
        load_coef(16384);
        send(1000); send(0); send(0); send(0);
        drain();
        check("impulse_last", out_data, 125);
        check("impulse_sat", sat_flag, 0);

        // Saturation positive then negative
        load_coef(32767);
        do_clear();
        send(65535); send(65535);
        drain();
        check("sat_pos_data", out_data, 65535);
        check("sat_pos_flag", sat_flag, 1);
        do_clear();
        send(-65536); send(-65536);
        drain();
        check("sat_neg_data", out_data, -65536);
        check("sat_neg_flag", sat_flag, 1);

        // Backpressure: 5 stalled cycles in HOLD with in_valid high
        out_ready = 1'b0;
        send(300);
        in_valid = 1'b1;
        in_data  = 17'sd77;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        send(77);
        drain();

        // Coefficient timing: load 0 on the accept edge of a sample
        do_clear();
        load_coef(16384);
        send(1000);
        send(0, 1'b1, 0);
        send(0);
        drain();
        check("coef_timing_last", out_data, 0);

        // Clear during CALC, then coefficient still in place
        do_clear();
        load_coef(16384);
        send(500);
        send(900, 1'b0, 0, 1'b1);
        send(200);
        send(0);
        drain();
        check("post_clear_coef", out_data, 100);

        // Enable low blocks accepts
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = 17'sd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("enable_low_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        tick();

        // Reset asserted asynchronously mid-HOLD (sat_flag set beforehand)
        load_coef(32767);
        send(65535); send(65535);
        drain();
        out_ready = 1'b0;
        send(1234);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_in_ready", in_ready, 0);
        check("async_rst_sat_flag", sat_flag, 0);
        exp_q.delete();
        m_y = 0; m_sat = 1'b0; m_shadow = 30802;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rst_release_in_ready", in_ready, 1);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int unsigned r;
            r = $urandom_range(0, 19);
            if (r < 3) begin
                drain();
                load_coef((r == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 32767));
            end else if (r == 3) begin
                drain();
                do_clear();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            send(longint'($urandom_range(0, 131071)) - 65536);
            if ((n % 10) == 9) begin
                drain();
                check("rand_sat_flag", sat_flag, m_sat);
            end
        end
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
